jtag_scan_sequencer: RTL and testbench

JTAG_SCAN_SEQUENCER -- requirements
Module: jtag_scan_sequencer

---
 rtl/jtag_scan_sequencer.sv | 270 +++++++++++++++++++++++++++
 tb/tb_jtag_scan_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_scan_sequencer.sv
//==============================================================================
// Module   : jtag_scan_sequencer
// Purpose  : Drives a JTAG TAP through TAP-reset, IR-scan, DR-scan and
//            idle-cycle commands. It presents registered TMS/TDI, captures
//            TDO into a right-aligned response word and mirrors the target
//            TAP state.
// Ports    : TCK        - JTAG clock (only clock)
//            TRST       - synchronous active-low reset
//            cmd_valid  - command offered
//            cmd_ready  - command can be accepted (IDLE only)
//            cmd_type   - 00 TAP reset, 01 IR scan, 10 DR scan, 11 idle
//            cmd_len    - bit count / idle cycle count (legal 1..32)
//            cmd_data   - TDI bits, LSB shifted first
//            TMS, TDI   - registered outputs to the target
//            TDO        - serial data from the target
//            rsp_valid  - one-cycle response strobe
//            rsp_data   - captured TDO bits, first bit in bit 0
//            rsp_err    - command rejected (qualified by rsp_valid)
//            busy       - inverse of cmd_ready
//            tap_state  - mirrored TAP state, standard 16-state encoding
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module jtag_scan_sequencer (
    input  logic        TCK,
    input  logic        TRST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_type,
    input  logic [5:0]  cmd_len,
    input  logic [31:0] cmd_data,
    output logic        TMS,
    output logic        TDI,
    input  logic        TDO,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic [3:0]  tap_state
);

    localparam logic [1:0] c_CMD_TAP_RESET = 2'b00;
    localparam logic [1:0] c_CMD_IR_SCAN   = 2'b01;
    localparam logic [1:0] c_CMD_IDLE      = 2'b11;

    localparam logic [3:0] c_TAP_TLR       = 4'h0;
    localparam logic [3:0] c_TAP_RTI       = 4'h1;
    localparam logic [3:0] c_TAP_SEL_DR    = 4'h2;
    localparam logic [3:0] c_TAP_CAP_DR    = 4'h3;
    localparam logic [3:0] c_TAP_SHIFT_DR  = 4'h4;
    localparam logic [3:0] c_TAP_EXIT1_DR  = 4'h5;
    localparam logic [3:0] c_TAP_PAUSE_DR  = 4'h6;
    localparam logic [3:0] c_TAP_EXIT2_DR  = 4'h7;
    localparam logic [3:0] c_TAP_UPD_DR    = 4'h8;
    localparam logic [3:0] c_TAP_SEL_IR    = 4'h9;
    localparam logic [3:0] c_TAP_CAP_IR    = 4'hA;
    localparam logic [3:0] c_TAP_SHIFT_IR  = 4'hB;
    localparam logic [3:0] c_TAP_EXIT1_IR  = 4'hC;
    localparam logic [3:0] c_TAP_PAUSE_IR  = 4'hD;
    localparam logic [3:0] c_TAP_EXIT2_IR  = 4'hE;
    localparam logic [3:0] c_TAP_UPD_IR    = 4'hF;

    typedef enum logic [2:0] {
        S_RST_SEQ = 3'd0,
        S_IDLE    = 3'd1,
        S_ENTER   = 3'd2,
        S_SHIFT   = 3'd3,
        S_EXIT    = 3'd4,
        S_WAIT    = 3'd5,
        S_RESP    = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [5:0]  bit_q, bit_d;
    logic [1:0]  type_q, type_d;
    logic [5:0]  len_q, len_d;
    logic [31:0] data_q, data_d;
    logic        tms_q, tms_d;
    logic        tdi_q, tdi_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [3:0]  tap_q;

    logic        w_len_bad;
    logic        w_is_ir;
    logic [5:0]  w_entry_len;
    logic [5:0]  w_last_bit;
    logic [5:0]  w_bit_inc;

    // IEEE 1149.1 TAP transition, evaluated with the TMS the target samples.
    function automatic logic [3:0] tap_next(input logic [3:0] s, input logic tms);
        logic [3:0] n;
        n = c_TAP_TLR;
        case (s)
            c_TAP_TLR:      n = tms ? c_TAP_TLR      : c_TAP_RTI;
            c_TAP_RTI:      n = tms ? c_TAP_SEL_DR   : c_TAP_RTI;
            c_TAP_SEL_DR:   n = tms ? c_TAP_SEL_IR   : c_TAP_CAP_DR;
            c_TAP_CAP_DR:   n = tms ? c_TAP_EXIT1_DR : c_TAP_SHIFT_DR;
            c_TAP_SHIFT_DR: n = tms ? c_TAP_EXIT1_DR : c_TAP_SHIFT_DR;
            c_TAP_EXIT1_DR: n = tms ? c_TAP_UPD_DR   : c_TAP_PAUSE_DR;
            c_TAP_PAUSE_DR: n = tms ? c_TAP_EXIT2_DR : c_TAP_PAUSE_DR;
            c_TAP_EXIT2_DR: n = tms ? c_TAP_UPD_DR   : c_TAP_SHIFT_DR;
            c_TAP_UPD_DR:   n = tms ? c_TAP_SEL_DR   : c_TAP_RTI;
            c_TAP_SEL_IR:   n = tms ? c_TAP_TLR      : c_TAP_CAP_IR;
            c_TAP_CAP_IR:   n = tms ? c_TAP_EXIT1_IR : c_TAP_SHIFT_IR;
            c_TAP_SHIFT_IR: n = tms ? c_TAP_EXIT1_IR : c_TAP_SHIFT_IR;
            c_TAP_EXIT1_IR: n = tms ? c_TAP_UPD_IR   : c_TAP_PAUSE_IR;
            c_TAP_PAUSE_IR: n = tms ? c_TAP_EXIT2_IR : c_TAP_PAUSE_IR;
            c_TAP_EXIT2_IR: n = tms ? c_TAP_UPD_IR   : c_TAP_SHIFT_IR;
            c_TAP_UPD_IR:   n = tms ? c_TAP_SEL_DR   : c_TAP_RTI;
            default:        n = c_TAP_TLR;
        endcase
        return n;
    endfunction

    assign w_len_bad   = (cmd_len == 6'd0) || (cmd_len > 6'd32);
    assign w_is_ir     = (type_q == c_CMD_IR_SCAN);
    // DR entry is 1,0,0 (3 edges); IR entry is 1,1,0,0 (4 edges).
    assign w_entry_len = w_is_ir ? 6'd4 : 6'd3;
    assign w_last_bit  = len_q - 6'd1;
    assign w_bit_inc   = bit_q + 6'd1;

    // Every TMS/TDI value computed here is registered and therefore seen by
    // the target one edge later. The acceptance edge already drives the first
    // sequence bit so the scan length comes out as cmd_len+5 (DR) edges.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        type_d      = type_q;
        len_d       = len_q;
        data_d      = data_q;
        tms_d       = 1'b0;
        tdi_d       = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            S_RST_SEQ: begin
                // cnt 0..4 drive TMS=1, cnt 5 drives TMS=0, cnt 6 is the edge
                // on which the target reaches RUN_TEST_IDLE.
                if (cnt_q == 6'd6) begin
                    state_d = S_IDLE;
                end else begin
                    tms_d = (cnt_q < 6'd5);
                    cnt_d = cnt_q + 6'd1;
                end
            end

            S_IDLE: begin
                if (cmd_valid) begin
                    type_d     = cmd_type;
                    len_d      = cmd_len;
                    data_d     = cmd_data;
                    rsp_data_d = '0;
                    cnt_d      = 6'd1;
                    bit_d      = '0;
                    if (cmd_type == c_CMD_TAP_RESET) begin
                        tms_d   = 1'b1;
                        state_d = S_RST_SEQ;
                    end else if (w_len_bad) begin
                        // Rejected: answer immediately, no TMS activity.
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (cmd_type == c_CMD_IDLE) begin
                        state_d = S_WAIT;
                    end else begin
                        tms_d   = 1'b1;
                        state_d = S_ENTER;
                    end
                end
            end

            S_ENTER: begin
                if (cnt_q == w_entry_len) begin
                    // Target enters SHIFT on this edge: present bit 0.
                    tdi_d   = data_q[0];
                    tms_d   = (len_q == 6'd1);
                    bit_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    tms_d = w_is_ir && (cnt_q == 6'd1);
                    cnt_d = cnt_q + 6'd1;
                end
            end

            S_SHIFT: begin
                // The target shifts bit_q on this edge; TDO is valid now.
                rsp_data_d[bit_q[4:0]] = TDO;
                if (bit_q == w_last_bit) begin
                    tms_d   = 1'b1;
                    state_d = S_EXIT;
                end else begin
                    tdi_d = data_q[w_bit_inc[4:0]];
                    tms_d = (w_bit_inc == w_last_bit);
                    bit_d = w_bit_inc;
                end
            end

            S_EXIT: begin
                state_d = S_RESP;
            end

            S_RESP: begin
                rsp_valid_d = 1'b1;
                state_d     = S_IDLE;
            end

            S_WAIT: begin
                if (cnt_q >= len_q) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end

            default: begin
                state_d = S_RST_SEQ;
                cnt_d   = '0;
                tms_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge TCK) begin
        if (!TRST) begin
            state_q     <= S_RST_SEQ;
            cnt_q       <= '0;
            bit_q       <= '0;
            type_q      <= '0;
            len_q       <= '0;
            data_q      <= '0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            tap_q       <= c_TAP_TLR;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            type_q      <= type_d;
            len_q       <= len_d;
            data_q      <= data_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            tap_q       <= tap_next(tap_q, tms_q);
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = ~cmd_ready;
    assign TMS       = tms_q;
    assign TDI       = tdi_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;
    assign tap_state = tap_q;

endmodule

`default_nettype wire

// File: tb/tb_jtag_scan_sequencer.sv
//==============================================================================
// Module   : tb_jtag_scan_sequencer
// Purpose  : Scoreboard bench for jtag_scan_sequencer. Stimulus pushes the
//            expected per-edge TMS/TDI/TAP trace and expected responses into
//            queues; a negedge monitor pops and compares them.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_jtag_scan_sequencer;

    logic        TCK = 1'b0;
    logic        TRST = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_type = 2'b00;
    logic [5:0]  cmd_len = 6'd0;
    logic [31:0] cmd_data = 32'd0;
    logic        TMS;
    logic        TDI;
    logic        TDO;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic [3:0]  tap_state;
    logic        tdo_tied = 1'b0;

    // Loopback of TDI, or tied high.
    assign TDO = tdo_tied ? 1'b1 : TDI;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       tms;
        logic       tdi_chk;
        logic       tdi;
        logic [3:0] tap;
    } tr_t;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    tr_t  trq[$];
    rsp_t rsq[$];
    tr_t  pend;
    bit   have_pend = 1'b0;

    jtag_scan_sequencer dut (
        .TCK       (TCK),
        .TRST      (TRST),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_type  (cmd_type),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .TMS       (TMS),
        .TDI       (TDI),
        .TDO       (TDO),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .tap_state (tap_state)
    );

    always #5 TCK = ~TCK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic tms, input logic c, input logic tdi, input logic [3:0] tap);
        tr_t e;
        e.tms = tms; e.tdi_chk = c; e.tdi = tdi; e.tap = tap;
        trq.push_back(e);
    endtask

    // Expected trace for edges anchor+1 .. anchor+N (TMS/TDI sampled by the
    // target on that edge, and the TAP state after it).
    task automatic push_trace(input logic [1:0] t, input logic [5:0] l, input logic [31:0] d);
        logic [3:0] sh, ex1, upd;
        if (t == 2'b00) begin
            push(1, 0, 0, 4'h2); push(1, 0, 0, 4'h9); push(1, 0, 0, 4'h0);
            push(1, 0, 0, 4'h0); push(1, 0, 0, 4'h0); push(0, 0, 0, 4'h1);
        end else if (l == 6'd0 || l > 6'd32) begin
            push(0, 0, 0, 4'h1);
        end else if (t == 2'b11) begin
            for (int i = 0; i < int'(l); i++) push(0, 0, 0, 4'h1);
        end else begin
            if (t == 2'b10) begin
                push(1, 0, 0, 4'h2); push(0, 0, 0, 4'h3); push(0, 0, 0, 4'h4);
                sh = 4'h4; ex1 = 4'h5; upd = 4'h8;
            end else begin
                push(1, 0, 0, 4'h2); push(1, 0, 0, 4'h9);
                push(0, 0, 0, 4'hA); push(0, 0, 0, 4'hB);
                sh = 4'hB; ex1 = 4'hC; upd = 4'hF;
            end
            for (int i = 0; i < int'(l); i++)
                push(i == int'(l) - 1, 1, d[i], (i == int'(l) - 1) ? ex1 : sh);
            push(1, 0, 0, upd);
            push(0, 0, 0, 4'h1);
        end
    endtask

    // Monitor: trace and response scoreboard, sampled on the falling edge.
    always @(negedge TCK) begin
        rsp_t r;
        if (have_pend) begin
            chk("tap_state", {28'd0, tap_state}, {28'd0, pend.tap});
            have_pend = 1'b0;
        end
        if (trq.size() > 0) begin
            pend = trq.pop_front();
            have_pend = 1'b1;
            chk("tms", {31'd0, TMS}, {31'd0, pend.tms});
            if (pend.tdi_chk) chk("tdi", {31'd0, TDI}, {31'd0, pend.tdi});
        end
        if (rsp_valid === 1'b1) begin
            if (rsq.size() == 0) begin
                chk("unexpected_rsp_valid", 32'd1, 32'd0);
            end else begin
                r = rsq.pop_front();
                chk("rsp_data", rsp_data, r.data);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, r.err});
            end
        end
        if (busy !== ~cmd_ready) chk("busy_vs_ready", {31'd0, busy}, {31'd0, ~cmd_ready});
    end

    task automatic wait_ready(input string name, input int exp_edges);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(posedge TCK); #1;
            n++;
            cmd_valid = 1'b0;
        end
        chk(name, n, exp_edges);
    endtask

    task automatic do_cmd(input string name, input logic [1:0] t, input logic [5:0] l,
                          input logic [31:0] d, input int exp_edges, input bit rsp_en,
                          input logic [31:0] rsp_d, input logic rsp_e, input bit intrude);
        rsp_t r;
        @(negedge TCK);
        cmd_valid = 1'b1; cmd_type = t; cmd_len = l; cmd_data = d;
        @(posedge TCK); #1;
        if (intrude) begin
            // Offered while busy: must be ignored (would otherwise error).
            cmd_type = 2'b10; cmd_len = 6'd0;
        end else begin
            cmd_valid = 1'b0;
        end
        push_trace(t, l, d);
        if (rsp_en) begin
            r.data = rsp_d; r.err = rsp_e;
            rsq.push_back(r);
        end
        wait_ready(name, exp_edges);
    endtask

    task automatic do_reset();
        @(negedge TCK);
        TRST = 1'b0;
        @(posedge TCK); #1;
        chk("rst_tms", {31'd0, TMS}, 32'd1);
        chk("rst_tdi", {31'd0, TDI}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_tap", {28'd0, tap_state}, 32'd0);
        TRST = 1'b1;
        for (int i = 0; i < 6; i++) push(1, 0, 0, 4'h0);
        push(0, 0, 0, 4'h1);
        wait_ready("rst_release_ready", 7);
    endtask

    initial begin
        do_reset();

        tdo_tied = 1'b0;
        do_cmd("dr8_a5",   2'b10, 6'd8,  32'h0000_00A5, 13, 1, 32'h0000_00A5, 1'b0, 0);
        tdo_tied = 1'b1;
        do_cmd("ir4_3",    2'b01, 6'd4,  32'h0000_0003, 10, 1, 32'h0000_000F, 1'b0, 0);
        tdo_tied = 1'b0;
        do_cmd("idle3",    2'b11, 6'd3,  32'h0,          3, 0, 32'h0,         1'b0, 1);
        do_cmd("dr_len0",  2'b10, 6'd0,  32'hFFFF_FFFF,  0, 1, 32'h0,         1'b1, 0);
        do_cmd("dr_len33", 2'b10, 6'd33, 32'hFFFF_FFFF,  0, 1, 32'h0,         1'b1, 0);
        do_cmd("idle_len0",2'b11, 6'd0,  32'h0,          0, 1, 32'h0,         1'b1, 0);
        do_cmd("tap_reset",2'b00, 6'd0,  32'h0,          6, 0, 32'h0,         1'b0, 0);
        do_cmd("dr32",     2'b10, 6'd32, 32'hDEAD_BEEF, 37, 1, 32'hDEAD_BEEF, 1'b0, 0);
        tdo_tied = 1'b1;
        do_cmd("dr1",      2'b10, 6'd1,  32'h0,          6, 1, 32'h0000_0001, 1'b0, 0);
        tdo_tied = 1'b0;

        // Abort a 32-bit DR scan mid-shift with a reset pulse.
        @(negedge TCK);
        cmd_valid = 1'b1; cmd_type = 2'b10; cmd_len = 6'd32; cmd_data = 32'h1234_5678;
        @(posedge TCK); #1;
        cmd_valid = 1'b0;
        repeat (10) @(posedge TCK);
        #1;
        chk("mid_busy", {31'd0, busy}, 32'd1);
        chk("mid_tap_shift_dr", {28'd0, tap_state}, 32'h4);
        do_reset();

        do_cmd("dr5_after_rst", 2'b10, 6'd5, 32'h0000_0015, 10, 1, 32'h0000_0015, 1'b0, 0);

        repeat (3) @(posedge TCK);
        #1;
        chk("trace_queue_empty", trq.size(), 32'd0);
        chk("rsp_queue_empty", rsq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
